// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared mode encoding and width defaults for the immediate
//               extender pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    localparam int c_MODE_W = 2;
    localparam int c_IN_W   = 16;
    localparam int c_OUT_W  = 32;

    typedef enum logic [c_MODE_W-1:0] {
        IMM_SIGN   = 2'd0,
        IMM_ZERO   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_e;

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational mode mux turning an immediate into an operand.
//               Mode 3 (BRANCH) is legal only when IMM_EXT_BRANCH_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = c_IN_W,
    parameter int OUT_W = c_OUT_W
) (
    input  logic [IN_W-1:0]     i_imm,
    input  logic [c_MODE_W-1:0] i_mode,
    output logic [OUT_W-1:0]    o_data,
    output logic                o_err
);

    logic [OUT_W-1:0] w_sext;

    assign w_sext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};

    always_comb begin
        o_data = '0;
        o_err  = 1'b0;
        case (imm_mode_e'(i_mode))
            IMM_SIGN:  o_data = w_sext;
            IMM_ZERO:  o_data = {{(OUT_W-IN_W){1'b0}}, i_imm};
            // imm occupies the top IN_W bits; it always fits since IN_W < OUT_W
            IMM_UPPER: o_data = {i_imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
            IMM_BRANCH: o_data = {w_sext[OUT_W-3:0], 2'b00};
`endif
            default: begin
                o_data = '0;
                o_err  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Two-stage valid/ready immediate extender with saturating
//               illegal-mode counter. Optional BRANCH mode: IMM_EXT_BRANCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = c_IN_W,
    parameter int OUT_W    = c_OUT_W,
    parameter int TAG_W    = 5,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_imm,
    input  logic [c_MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_count
);

    logic                r_s1_valid;
    logic [IN_W-1:0]     r_s1_imm;
    logic [c_MODE_W-1:0] r_s1_mode;
    logic [TAG_W-1:0]    r_s1_tag;

    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_data;
    logic [TAG_W-1:0]    r_out_tag;
    logic                r_out_err;
    logic [ERRCNT_W-1:0] r_err_count;

    logic                w_s2_load;
    logic                w_in_fire;
    logic                w_out_fire;
    logic [OUT_W-1:0]    w_core_data;
    logic                w_core_err;

    assign w_s2_load  = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_load;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_imm  (r_s1_imm),
        .i_mode (r_s1_mode),
        .o_data (w_core_data),
        .o_err  (w_core_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_imm   <= '0;
            r_s1_mode  <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_imm   <= in_imm;
                r_s1_mode  <= in_mode;
                r_s1_tag   <= in_tag;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Payload only reloads with a real beat so an idle output stays quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_core_data;
                r_out_tag  <= r_s1_tag;
                r_out_err  <= w_core_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_out_fire && r_out_err && !(&r_err_count)) begin
            r_err_count <= r_err_count + ERRCNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Self-checking bench for imm_extend_pipe (table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;
    logic [7:0]  err_count;

    imm_extend_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [4:0]  tag;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
        int          acc_cyc;
        bit          chk_lat;
    } sb_item_t;

    localparam int NV = 11;
    vec_t     vecs [NV];
    sb_item_t sb [$];
    int       out_cycs [$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       exp_errs = 0;
    bit       free_run = 1'b1;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic monitor();
        sb_item_t it;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                out_cycs.push_back(cyc);
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_beat", {27'd0, out_tag, out_data}, 0);
                end else begin
                    it = sb.pop_front();
                    check(out_data === it.data, "out_data", out_data, it.data);
                    check(out_tag === it.tag && out_err === it.err, "out_tag_err",
                          {out_tag, out_err}, {it.tag, it.err});
                    if (it.err) exp_errs++;
                    if (it.chk_lat) check((cyc - it.acc_cyc) == 2, "latency", cyc - it.acc_cyc, 2);
                end
            end
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input vec_t v);
        int       b = 0;
        sb_item_t it;
        in_valid = 1'b1;
        in_imm   = v.imm;
        in_mode  = v.mode;
        in_tag   = v.tag;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            b++;
            if (b > 200) begin
                check(1'b0, "accept_timeout", 0, 1);
                break;
            end
        end
        it.data = v.exp_data;
        it.tag = v.tag;
        it.err = v.exp_err;
        it.acc_cyc = cyc;
        it.chk_lat = free_run;
        if (b <= 200) sb.push_back(it);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (!(sb.size() == 0 && out_valid === 1'b0)) begin
            @(negedge clk);
            b++;
            if (b > 2000) begin
                check(1'b0, "drain_timeout", sb.size(), 0);
                break;
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v3;
        vec_t vb;
        int   base;
        logic [31:0] s_data;
        logic [4:0]  s_tag;

        vecs[0]  = '{16'h8001, 2'd0, 5'd3,  32'hFFFF8001, 1'b0};
        vecs[1]  = '{16'h8001, 2'd1, 5'd4,  32'h00008001, 1'b0};
        vecs[2]  = '{16'h1234, 2'd2, 5'd5,  32'h12340000, 1'b0};
        vecs[3]  = '{16'h7FFF, 2'd0, 5'd6,  32'h00007FFF, 1'b0};
        vecs[4]  = '{16'hFFFF, 2'd1, 5'd7,  32'h0000FFFF, 1'b0};
        vecs[5]  = '{16'hFFFF, 2'd2, 5'd8,  32'hFFFF0000, 1'b0};
        vecs[6]  = '{16'h0000, 2'd0, 5'd9,  32'h00000000, 1'b0};
        vecs[7]  = '{16'hFFFF, 2'd0, 5'd10, 32'hFFFFFFFF, 1'b0};
`ifdef IMM_EXT_BRANCH_EN
        vecs[8]  = '{16'hFFFF, 2'd3, 5'd11, 32'hFFFFFFFC, 1'b0};
        vecs[9]  = '{16'h0001, 2'd3, 5'd12, 32'h00000004, 1'b0};
        vecs[10] = '{16'h8000, 2'd3, 5'd13, 32'hFFFE0000, 1'b0};
`else
        vecs[8]  = '{16'hFFFF, 2'd3, 5'd11, 32'h00000000, 1'b1};
        vecs[9]  = '{16'h0001, 2'd3, 5'd12, 32'h00000000, 1'b1};
        vecs[10] = '{16'h8000, 2'd3, 5'd13, 32'h00000000, 1'b1};
`endif
        v3 = vecs[8];

        rst = 1'b1;
        in_valid = 1'b0;
        in_imm = '0;
        in_mode = '0;
        in_tag = '0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check(out_valid === 1'b0 && out_err === 1'b0, "rst_valid_err", {out_valid, out_err}, 0);
        check(out_data === 32'd0 && out_tag === 5'd0, "rst_data_tag", {out_tag, out_data}, 0);
        check(err_count === 8'd0, "rst_err_count", err_count, 0);
        align();
        rst = 1'b0;
        @(negedge clk);
        check(in_ready === 1'b1, "in_ready_after_rst", in_ready, 1);

        // Single beat, then the whole table back to back.
        align();
        send(vecs[0]);
        drain();
        align();
        base = out_cycs.size();
        for (int i = 0; i < NV; i++) send(vecs[i]);
        drain();
        check(out_cycs.size() - base == NV, "stream_count", out_cycs.size() - base, NV);
        for (int i = base + 1; i < out_cycs.size(); i++)
            check(out_cycs[i] - out_cycs[i-1] == 1, "stream_gap", out_cycs[i] - out_cycs[i-1], 1);
        check(err_count === 8'(sat255(exp_errs)), "err_count_table", err_count, sat255(exp_errs));

        // Stall with both stages full, then release with a beat waiting.
        align();
        out_ready = 1'b0;
        free_run  = 1'b0;
        base = out_cycs.size();
        send(vecs[1]);
        send(vecs[2]);
        in_valid = 1'b1;
        in_imm   = vecs[5].imm;
        in_mode  = vecs[5].mode;
        in_tag   = vecs[5].tag;
        @(negedge clk);
        s_data = out_data;
        s_tag  = out_tag;
        check(in_ready === 1'b0 && out_valid === 1'b1, "full_stall", {in_ready, out_valid}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(in_ready === 1'b0, "stall_in_ready", in_ready, 0);
            check(out_data === s_data && out_tag === s_tag && out_valid === 1'b1,
                  "stall_hold", {out_valid, out_tag, out_data}, {1'b1, s_tag, s_data});
        end
        align();
        out_ready = 1'b1;
        send(vecs[5]);
        drain();
        free_run = 1'b1;
        check(out_cycs.size() - base == 3, "stall_beat_count", out_cycs.size() - base, 3);

        // Illegal / branch mode and counter saturation, from a clean reset.
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        sb.delete();
        exp_errs = 0;
        align();
        send(v3);
        drain();
`ifdef IMM_EXT_BRANCH_EN
        check(err_count === 8'd0, "err_count_one", err_count, 0);
`else
        check(err_count === 8'd1, "err_count_one", err_count, 1);
`endif
        align();
        for (int i = 1; i < 300; i++) begin
            vb = v3;
            vb.tag = 5'(i);
            send(vb);
        end
        drain();
`ifdef IMM_EXT_BRANCH_EN
        check(err_count === 8'd0, "err_count_sat", err_count, 0);
`else
        check(err_count === 8'd255, "err_count_sat", err_count, 255);
`endif
        check(err_count === 8'(sat255(exp_errs)), "err_count_model", err_count, sat255(exp_errs));

        // Asynchronous reset with both stages full.
        align();
        out_ready = 1'b0;
        free_run  = 1'b0;
        send(v3);
        send(vecs[3]);
        rst = 1'b1;
        #1;
        check(out_valid === 1'b0 && err_count === 8'd0, "async_rst", {out_valid, err_count}, 0);
        check(out_data === 32'd0 && out_tag === 5'd0 && out_err === 1'b0, "async_rst_data",
              {out_err, out_tag, out_data}, 0);
        sb.delete();
        exp_errs = 0;
        align();
        rst = 1'b0;
        out_ready = 1'b1;
        free_run  = 1'b1;
        @(negedge clk);
        check(in_ready === 1'b1, "in_ready_post_rst", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(out_valid === 1'b0, "no_stale_beat", out_valid, 0);
        end
        align();
        send(vecs[2]);
        drain();
        check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
